// File: rtl/demux_pkg.sv
// Shared constants, state type and select helper for the demux frame sequencer.
package demux_pkg;

  localparam int NCH  = 8;
  localparam int SELW = 3;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Channel number to {s1,s2,s3}; s1 carries the channel MSB.
  function automatic logic [SELW-1:0] ch_to_sel(input logic [SELW-1:0] ch);
    return ch;
  endfunction

endpackage

// File: rtl/demux_frame_sequencer_if.sv
// Frame handshake and demux drive bundle for the demux frame sequencer.
//
// Handshake: a frame transfers on a rising clk edge where in_valid and
// in_ready are both high and flush is low. The producer holds in_data stable
// while in_valid is high; in_data is only sampled on that transfer edge.
interface demux_frame_sequencer_if;
  import demux_pkg::*;

  logic [NCH-1:0] in_data;
  logic           in_valid;
  logic           in_ready;
  logic           flush;
  logic           a;
  logic           s1;
  logic           s2;
  logic           s3;
  logic           busy;
  logic           done;
  state_t         dbg_state;

  modport master (
    output in_data, in_valid, flush,
    input  in_ready, a, s1, s2, s3, busy, done, dbg_state
  );

  modport slave (
    input  in_data, in_valid, flush,
    output in_ready, a, s1, s2, s3, busy, done, dbg_state
  );

endinterface

// File: rtl/demux_dwell_timer.sv
// Per-channel hold counter: last is high in the final cycle of each dwell.
module demux_dwell_timer #(
  parameter int DWELL = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic last
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] LAST_VAL = CW'(DWELL - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign last = (cnt_q == LAST_VAL);

  // Next count: wrap to zero at the end of each dwell, hold when not running.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = last ? '0 : cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/demux_frame_sequencer.sv
// Walks a latched 8-bit frame across the 1x8 demux, one channel per dwell.
module demux_frame_sequencer
  import demux_pkg::*;
#(
  parameter int DWELL = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  demux_frame_sequencer_if.slave  bus
);

  state_t          state_q;
  logic [NCH-1:0]  frame_q;
  logic [SELW-1:0] ch_q;
  logic [SELW-1:0] sel_q;
  logic            a_q;
  logic            busy_q;
  logic            done_q;
  logic            in_ready_q;

  logic            running;
  logic            dwell_clear;
  logic            dwell_last;
  logic            accept;
  logic [SELW-1:0] ch_inc;

  assign running     = (state_q == RUN);
  assign dwell_clear = !running || bus.flush;
  assign accept      = bus.in_valid && in_ready_q && !bus.flush;
  assign ch_inc      = ch_q + 1'b1;

  demux_dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (dwell_clear),
    .run   (running),
    .last  (dwell_last)
  );

  // Sequencer FSM; every demux-facing output is registered here so that a
  // and the selects always change on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      frame_q    <= '0;
      ch_q       <= '0;
      sel_q      <= '0;
      a_q        <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      in_ready_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          a_q        <= 1'b0;
          sel_q      <= '0;
          ch_q       <= '0;
          if (accept) begin
            frame_q    <= bus.in_data;
            a_q        <= bus.in_data[0];
            sel_q      <= ch_to_sel('0);
            busy_q     <= 1'b1;
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          if (bus.flush) begin
            state_q    <= IDLE;
            ch_q       <= '0;
            a_q        <= 1'b0;
            sel_q      <= '0;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
          end else if (dwell_last) begin
            if (ch_q == SELW'(NCH - 1)) begin
              state_q    <= IDLE;
              ch_q       <= '0;
              a_q        <= 1'b0;
              sel_q      <= '0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              in_ready_q <= 1'b1;
            end else begin
              ch_q  <= ch_inc;
              a_q   <= frame_q[ch_inc];
              sel_q <= ch_to_sel(ch_inc);
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.a         = a_q;
  assign bus.s1        = sel_q[2];
  assign bus.s2        = sel_q[1];
  assign bus.s3        = sel_q[0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_demux_frame_sequencer.sv
// Bench for demux_frame_sequencer: DWELL=1 and DWELL=3 instances share one
// stimulus stream and are each compared against a timing-formula model.
module tb_demux_frame_sequencer;
  import demux_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       flush;

  always #5 clk = ~clk;

  demux_frame_sequencer_if bus1();
  demux_frame_sequencer_if bus3();

  assign bus1.in_data  = in_data;
  assign bus1.in_valid = in_valid;
  assign bus1.flush    = flush;
  assign bus3.in_data  = in_data;
  assign bus3.in_valid = in_valid;
  assign bus3.flush    = flush;

  demux_frame_sequencer #(.DWELL(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  demux_frame_sequencer #(.DWELL(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  // ---------------- reference model ----------------
  int         total = 0;
  int         bad   = 0;
  int         cyc   = 0;
  int         dw[2] = '{1, 3};
  bit         m_up[2];
  bit         m_act[2];
  int         m_t[2];
  logic [7:0] m_fr[2];

  // Observed bits: {a,s1,s2,s3,busy,done,in_ready,state_is_run}
  function automatic logic [7:0] obs(input int i);
    if (i == 0)
      return {bus1.a, bus1.s1, bus1.s2, bus1.s3, bus1.busy, bus1.done,
              bus1.in_ready, bus1.dbg_state == RUN};
    return {bus3.a, bus3.s1, bus3.s2, bus3.s3, bus3.busy, bus3.done,
            bus3.in_ready, bus3.dbg_state == RUN};
  endfunction

  // Frame accepted at edge T: channel k shown for T+1+k*D .. T+(k+1)*D,
  // done at T+1+8*D. e counts cycles since the accept edge, starting at 1.
  function automatic logic [7:0] model_out(input int i);
    int         e;
    int         k;
    logic [2:0] ks;
    if (!m_up[i]) return 8'h00;
    e = cyc - m_t[i];
    if (m_act[i] && e <= 8 * dw[i]) begin
      k  = (e - 1) / dw[i];
      ks = k[2:0];
      return {m_fr[i][k], ks, 1'b1, 1'b0, 1'b0, 1'b1};
    end
    if (m_act[i] && e == 8 * dw[i] + 1) return 8'b0000_0110;
    return 8'b0000_0010;
  endfunction

  function automatic bit model_running(input int i);
    return m_up[i] && m_act[i] && ((cyc - m_t[i]) <= 8 * dw[i]);
  endfunction

  // ---------------- driver ----------------
  // One clock: decide model transitions from pre-edge inputs, cross the edge,
  // apply them, then settle on the falling edge for sampling.
  task automatic step();
    bit         acc[2];
    bit         fl[2];
    logic [7:0] d;
    bit         rst_at_edge;
    d = in_data;
    rst_at_edge = rst_n;
    for (int i = 0; i < 2; i++) begin
      acc[i] = m_up[i] && !model_running(i) && in_valid && !flush;
      fl[i]  = model_running(i) && flush;
    end
    @(posedge clk);
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (!rst_at_edge) begin
        m_up[i]  = 1'b0;
        m_act[i] = 1'b0;
      end else begin
        if (fl[i]) m_act[i] = 1'b0;
        if (acc[i]) begin
          m_act[i] = 1'b1;
          m_t[i]   = cyc - 1;
          m_fr[i]  = d;
        end
        m_up[i] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; in_data = 8'h00;
    for (int i = 0; i < 2; i++) begin m_up[i] = 0; m_act[i] = 0; m_t[i] = 0; m_fr[i] = 0; end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs(i) !== 8'h00) begin
        bad++; $display("FAIL reset_hold dut%0d got=%b exp=%b", i, obs(i), 8'h00);
      end
    end
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs(i) !== model_out(i)) begin
        bad++; $display("FAIL reset_release dut%0d cyc=%0d got=%b exp=%b", i, cyc, obs(i), model_out(i));
      end
    end
  endtask

  task automatic test_frame(input logic [7:0] f, input string name);
    in_data = f; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int n = 0; n < 30; n++) begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs(i) !== model_out(i)) begin
          bad++; $display("FAIL %s dut%0d cyc=%0d got=%b exp=%b", name, i, cyc, obs(i), model_out(i));
        end
      end
      in_data = 8'($urandom);
      if ($urandom_range(0, 1) == 1) in_valid = 1'b0;
      step();
    end
  endtask

  task automatic test_back_to_back();
    in_data = 8'hFF; in_valid = 1'b1;
    step();
    in_data = 8'h0F;
    for (int n = 0; n < 60; n++) begin
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs(i) !== model_out(i)) begin
          bad++; $display("FAIL back_to_back dut%0d cyc=%0d got=%b exp=%b", i, cyc, obs(i), model_out(i));
        end
      end
      if (n == 40) in_valid = 1'b0;
      step();
    end
  endtask

  task automatic test_flush_run();
    in_data = 8'hFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int n = 0; n < 32; n++) begin
      flush = (n == 3);
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs(i) !== model_out(i)) begin
          bad++; $display("FAIL flush_run dut%0d cyc=%0d got=%b exp=%b", i, cyc, obs(i), model_out(i));
        end
      end
      step();
    end
    flush = 1'b0;
  endtask

  task automatic test_flush_idle();
    in_data = 8'hFF; in_valid = 1'b1; flush = 1'b1;
    for (int n = 0; n < 32; n++) begin
      if (n == 2) flush = 1'b0;
      if (n == 3) in_valid = 1'b0;
      step();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs(i) !== model_out(i)) begin
          bad++; $display("FAIL flush_idle dut%0d cyc=%0d got=%b exp=%b", i, cyc, obs(i), model_out(i));
        end
      end
    end
  endtask

  task automatic test_async_reset();
    in_data = 8'hFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin m_up[i] = 1'b0; m_act[i] = 1'b0; end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs(i) !== 8'h00) begin
        bad++; $display("FAIL async_reset dut%0d got=%b exp=%b", i, obs(i), 8'h00);
      end
    end
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 2; i++) begin
      total++;
      if (obs(i) !== model_out(i)) begin
        bad++; $display("FAIL async_release dut%0d cyc=%0d got=%b exp=%b", i, cyc, obs(i), model_out(i));
      end
    end
    test_frame(8'h01, "after_reset_01");
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      flush    = ($urandom_range(0, 15) == 0);
      in_data  = 8'($urandom);
      step();
      for (int i = 0; i < 2; i++) begin
        total++;
        if (obs(i) !== model_out(i)) begin
          bad++; $display("FAIL random dut%0d cyc=%0d got=%b exp=%b", i, cyc, obs(i), model_out(i));
        end
      end
    end
    in_valid = 1'b0; flush = 1'b0;
    repeat (30) step();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_frame(8'hA5, "frame_a5");
    test_frame(8'h81, "frame_81");
    test_frame(8'h00, "frame_00");
    test_back_to_back();
    test_flush_run();
    test_flush_idle();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule

// File: doc/demux_frame_sequencer.md
Name: demux_frame_sequencer

Overview:
Time-division driver that sits directly upstream of the 1x8 demultiplexer. It accepts an 8-bit frame over a valid/ready handshake and walks the demux select lines through channels 0..7. For each channel it presents that channel's frame bit on the demux data input for DWELL cycles. It pulses done after the last channel and keeps the demux data input low whenever idle.

Parameters:
NCH, 8, number of channels; fixed at 8 to match the 1x8 demux.
SELW, 3, select width, log2(NCH).
DWELL, 1, cycles each channel is held; legal range 1..255.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
in_data  input  NCH  frame; bit k is routed to demux channel k.
in_valid  input  1  frame offered.
in_ready  output  1  block can accept a frame this cycle.
flush  input  1  synchronous abort of the frame in progress.
a  output  1  demux data input.
s1  output  1  demux select MSB (channel bit 2).
s2  output  1  demux select (channel bit 1).
s3  output  1  demux select LSB (channel bit 0).
busy  output  1  frame in progress.
done  output  1  one-cycle pulse after the last channel completes.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values, applied immediately on rst_n low, including mid-frame: state IDLE, a=0, s1=s2=s3=0, busy=0, done=0, in_ready=0.
- in_ready rises on the first clk edge after rst_n deasserts.
- All outputs are registered.
- States: IDLE, RUN.
- IDLE:
  - in_ready=1, busy=0, a=0, selects=000.
  - Accept occurs when in_valid && in_ready && !flush at an edge. On accept: latch in_data, ch=0, dwell counter=0, go to RUN.
- RUN:
  - in_ready=0, busy=1.
  - {s1,s2,s3}=ch (s1 is MSB), a=frame[ch].
  - Dwell counter increments each cycle. When it reaches DWELL-1, it clears and ch increments.
  - When ch=7 and the counter reaches DWELL-1, the next state is IDLE and done=1 for exactly that next cycle. In that cycle a=0, selects=000 and in_ready=1.
- Latency:
  - Frame accepted at edge T.
  - Channel 0 is visible from T+1.
  - Channel k is visible for cycles T+1+k*DWELL .. T+(k+1)*DWELL.
  - done is high in cycle T+1+8*DWELL.
- Throughput: a new frame may be accepted in the same cycle done is high. Minimum frame period is 8*DWELL+1 cycles.
- in_data is sampled only at accept. Later changes to in_data, or in_valid while busy, have no effect.
- Frame 8'h00 still runs all 8 channels (a=0 throughout) and still produces done.
- flush:
  - In RUN: at the next edge go to IDLE, a=0, selects=000, no done pulse, frame discarded.
  - In IDLE: blocks acceptance that cycle. flush wins over a simultaneous in_valid.
- ch and the dwell counter never wrap in normal operation; leaving RUN resets both.
- Dwell counter width is max(1, clog2(DWELL)).
- Glitch-free demux drive: a and the selects update on the same edge.

Decomposition:
- Shared package demux_pkg holds:
  - NCH=8 and SELW=3 constants.
  - State enum state_t {IDLE, RUN}.
  - Function ch_to_sel(ch) returning {s1,s2,s3}.
- One natural sub-module: demux_dwell_timer (parameter DWELL; inputs clk, rst_n, clear, run; output last). It encapsulates the per-channel hold counter.
- Top level holds the FSM, frame register, channel counter and output registers.

Test Plan:
1. DWELL=1, in_data=8'hA5, in_valid pulsed at edge 0 -> cycles 1..8 selects 000..111, a=1,0,1,0,0,1,0,1; done=1 only in cycle 9; busy=1 in cycles 1..8; in_ready=0 in cycles 1..8.
2. DWELL=3, in_data=8'h81 -> each channel held 3 cycles; a=1 in cycles 1-3 and 22-24, else 0; done in cycle 25.
3. Back-to-back: in_valid held high with frames 8'hFF then 8'h0F -> second accept on the done cycle (cycle 9); second frame channel 0 appears in cycle 10; no idle gap beyond the done cycle.
4. flush asserted in cycle 4 of an 8'hFF frame (DWELL=1) -> cycle 5: a=0, selects=000, busy=0, in_ready=1, no done pulse ever for that frame.
5. rst_n pulled low asynchronously mid-frame (between edges, at channel 3) -> a, selects, busy, done go to 0 immediately without a clock; after release, in_ready=1 on the first edge and a new frame 8'h01 runs normally.
6. flush and in_valid both high in IDLE with in_data=8'hFF -> no accept, busy stays 0, a stays 0; frame accepted the next cycle once flush drops.
